// File: rtl/rsp_skid_fifo_if.sv
// Valid/ready channel carrying one response word.
// The master drives vld/dat and the slave returns rdy.
interface rsp_skid_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  vld;
   logic [DATA_WIDTH-1:0] dat;
   logic                  rdy;

   modport master (output vld, output dat, input  rdy);
   modport slave  (input  vld, input  dat, output rdy);
endinterface

// File: rtl/rsp_skid_fifo.sv
// DEPTH-entry elastic buffer on the memory-response path. Latency 1 cycle (0 with RSP_SKID_FIFO_BYPASS_EN).
// m_rsp.rdy is a registered not-full flag, so src.rdy never reaches it combinationally.
module rsp_skid_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   rsp_skid_fifo_if.slave       m_rsp,
   rsp_skid_fifo_if.master      src,
   output logic [CNT_WIDTH-1:0] count
);
   localparam int                   PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  rdy_q, rdy_d;
   logic                  empty;
   logic                  push, pop;
   logic                  wr_en, rd_en;

   assign empty     = (count_q == '0);
   assign push      = m_rsp.vld & rdy_q;
   assign m_rsp.rdy = rdy_q;
   assign count     = count_q;

`ifdef RSP_SKID_FIFO_BYPASS_EN
   // An empty buffer forwards the upstream word; it is stored only if the consumer stalls.
   logic byp;
   assign byp     = empty & m_rsp.vld;
   assign src.vld = ~empty | m_rsp.vld;
   assign src.dat = empty ? m_rsp.dat : mem_q[rd_ptr_q];
   assign pop     = src.vld & src.rdy;
   assign rd_en   = pop & ~empty;
   assign wr_en   = push & ~(byp & src.rdy);
`else
   assign src.vld = ~empty;
   assign src.dat = mem_q[rd_ptr_q];
   assign pop     = src.vld & src.rdy;
   assign rd_en   = pop;
   assign wr_en   = push;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
      // Ready for next cycle is decided from next-state occupancy only.
      rdy_d = (count_d != FULL_CNT);
   end

   always_ff @(posedge clk) begin
      if (wr_en && !flush) begin
         mem_q[wr_ptr_q] <= m_rsp.dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_q    <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdy_q    <= rdy_d;
      end
   end
endmodule
